// File: rtl/oclib_pkg.sv
// Shared CSR bus structs, router state encoding and router limits.
package oclib_pkg;

  localparam int CsrRouterMaxOutputs = 32;
  localparam int CsrBlockIdBits      = 8;
  localparam int CsrDataBits         = 32;

  typedef enum logic [2:0] {
    StIdle,
    StDecode,
    StAccess,
    StRespond,
    StWait
  } csr_router_state_e;

  typedef struct packed {
    logic        read;
    logic        write;
    logic [31:0] address;
    logic [31:0] wdata;
  } csr_32_s;

  // toblock sits in the MSBs so the remaining bits line up with csr_32_s.
  typedef struct packed {
    logic [CsrBlockIdBits-1:0] toblock;
    logic                      read;
    logic                      write;
    logic [31:0]               address;
    logic [31:0]               wdata;
  } csr_32_tree_s;

  typedef struct packed {
    logic        ready;
    logic        error;
    logic [31:0] rdata;
  } csr_32_fb_s;

  typedef struct packed {
    logic        ready;
    logic        error;
    logic [31:0] rdata;
  } csr_32_tree_fb_s;

endpackage

// File: rtl/oclib_csr_router_decode.sv
// Combinational toblock -> output select vector: key/mask match, lowest
// index wins, broadcast writes select every output.
module oclib_csr_router_decode
  import oclib_pkg::*;
#(
  parameter int                                                Outputs           = 8,
  parameter logic [CsrRouterMaxOutputs-1:0][CsrBlockIdBits-1:0] OutputBlockIdKey  = '1,
  parameter logic [CsrRouterMaxOutputs-1:0][CsrBlockIdBits-1:0] OutputBlockIdMask = '0,
  parameter bit                                                EnableBroadcast   = 1'b0,
  parameter logic [CsrBlockIdBits-1:0]                         BroadcastBlockId  = '1
) (
  input  logic [CsrBlockIdBits-1:0] i_toblock,
  input  logic                      i_write,
  output logic [Outputs-1:0]        o_sel
);

  // An all-ones key stands for "this output's own index".
  function automatic logic f_match(input int idx, input logic [CsrBlockIdBits-1:0] blk);
    logic [CsrBlockIdBits-1:0] key;
    logic [CsrBlockIdBits-1:0] care;
    care = ~OutputBlockIdMask[idx];
    key  = (OutputBlockIdKey[idx] == '1) ? CsrBlockIdBits'(idx) : OutputBlockIdKey[idx];
    return ((blk & care) == (key & care));
  endfunction

  always_comb begin
    o_sel = '0;
    for (int i = Outputs - 1; i >= 0; i--) begin
      if (f_match(i, i_toblock)) begin
        o_sel    = '0;
        o_sel[i] = 1'b1;
      end
    end
    // A broadcast read has no single source for rdata, so it decodes as a miss.
    if (EnableBroadcast && (i_toblock == BroadcastBlockId)) begin
      o_sel = i_write ? '1 : '0;
    end
  end

endmodule

// File: rtl/oclib_csr_tree_router.sv
// CSR tree branch router: decodes one upstream request to one (or, for
// broadcast writes, all) downstream ports, with miss and timeout responses.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// StIdle    | waiting for in.read/in.write; payload latched on entry
// StDecode  | select vector registered; miss goes straight to StRespond
// StAccess  | selected outputs driven until each readies or timer expires
// StRespond | single-cycle inFb.ready with captured rdata/error
// StWait    | outputs quiet, waiting for upstream to drop its request
module oclib_csr_tree_router
  import oclib_pkg::*;
#(
  parameter type CsrInType    = csr_32_tree_s,
  parameter type CsrInFbType  = csr_32_tree_fb_s,
  parameter type CsrOutType   = csr_32_s,
  parameter type CsrOutFbType = csr_32_fb_s,
  parameter int                                                Outputs           = 8,
  parameter logic [CsrRouterMaxOutputs-1:0][CsrBlockIdBits-1:0] OutputBlockIdKey  = '1,
  parameter logic [CsrRouterMaxOutputs-1:0][CsrBlockIdBits-1:0] OutputBlockIdMask = '0,
  parameter int                                                TimeoutCycles     = 1024,
  parameter bit                                                EnableBroadcast   = 1'b0,
  parameter logic [CsrBlockIdBits-1:0]                         BroadcastBlockId  = '1
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  CsrInType    i_in,
  output CsrInFbType  o_in_fb,
  output CsrOutType   o_out    [Outputs],
  input  CsrOutFbType i_out_fb [Outputs],
  output logic        o_status_miss,
  output logic        o_status_timeout
);

  localparam int                   TimerBits = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [TimerBits-1:0] TimerLoad = (TimeoutCycles > 0) ? TimerBits'(TimeoutCycles - 1) : '0;

  if ((Outputs < 1) || (Outputs > CsrRouterMaxOutputs)) begin : g_bad_outputs
    $error("oclib_csr_tree_router: Outputs must be 1..32");
  end
  if ((Outputs > 1) && ($bits(CsrInType) < $bits(CsrOutType) + CsrBlockIdBits)) begin : g_no_block
    $error("oclib_csr_tree_router: CsrInType lacks a block id field");
  end

  csr_router_state_e         r_state;
  csr_router_state_e         w_state_nxt;
  CsrOutType                 r_out_int;
  logic [CsrBlockIdBits-1:0] r_toblock;
  logic [Outputs-1:0]        r_sel;
  logic [Outputs-1:0]        r_done;
  logic [TimerBits-1:0]      r_timer;
  logic [CsrDataBits-1:0]    r_rdata;
  logic                      r_err;
  logic                      r_miss;
  logic                      r_tmo;

  logic [$bits(CsrOutType)-1:0] w_in_low;
  CsrOutType                    w_in_payload;
  logic [CsrBlockIdBits-1:0]    w_toblock;
  logic                         w_req;
  logic [Outputs-1:0]           w_sel;
  logic [Outputs-1:0]           w_hit;
  logic                         w_hit_err;
  logic [CsrDataBits-1:0]       w_hit_rdata;
  logic                         w_access;
  logic                         w_timeout;

  assign w_in_low  = i_in[$bits(CsrOutType)-1:0];
  assign w_toblock = i_in[$bits(CsrInType)-1 -: CsrBlockIdBits];
  assign w_req     = i_in.read | i_in.write;
  assign w_access  = (r_state == StAccess);

  // Write has priority when upstream raises both strobes.
  always_comb begin
    w_in_payload       = CsrOutType'(w_in_low);
    w_in_payload.read  = i_in.read & ~i_in.write;
    w_in_payload.write = i_in.write;
  end

  oclib_csr_router_decode #(
    .Outputs           (Outputs),
    .OutputBlockIdKey  (OutputBlockIdKey),
    .OutputBlockIdMask (OutputBlockIdMask),
    .EnableBroadcast   (EnableBroadcast),
    .BroadcastBlockId  (BroadcastBlockId)
  ) u_decode (
    .i_toblock (r_toblock),
    .i_write   (r_out_int.write),
    .o_sel     (w_sel)
  );

  always_comb begin
    w_hit       = '0;
    w_hit_err   = 1'b0;
    w_hit_rdata = '0;
    for (int i = 0; i < Outputs; i++) begin
      w_hit[i]    = w_access & r_sel[i] & ~r_done[i] & i_out_fb[i].ready;
      w_hit_err   = w_hit_err | (w_hit[i] & i_out_fb[i].error);
      w_hit_rdata = w_hit_rdata | (w_hit[i] ? i_out_fb[i].rdata : '0);
    end
  end

  // A ready landing on the last timer cycle completes the access instead.
  assign w_timeout = (TimeoutCycles != 0) && w_access && (r_timer == '0) &&
                     (r_done != r_sel) && ((r_done | w_hit) != r_sel);

  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= StIdle;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle:    if (w_req) w_state_nxt = StDecode;
      StDecode:  w_state_nxt = (w_sel == '0) ? StRespond : StAccess;
      StAccess:  if ((r_done == r_sel) || w_timeout) w_state_nxt = StRespond;
      StRespond: w_state_nxt = StWait;
      StWait:    if (!w_req) w_state_nxt = StIdle;
      default:   w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_out_int <= '0;
      r_toblock <= '0;
      r_sel     <= '0;
      r_done    <= '0;
      r_timer   <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_miss    <= 1'b0;
      r_tmo     <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_req) begin
            r_out_int <= w_in_payload;
            r_toblock <= w_toblock;
            r_done    <= '0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
            r_miss    <= 1'b0;
            r_tmo     <= 1'b0;
          end
        end
        StDecode: begin
          r_sel   <= w_sel;
          r_timer <= TimerLoad;
          if (w_sel == '0) begin
            r_err  <= 1'b1;
            r_miss <= 1'b1;
          end
        end
        StAccess: begin
          r_done <= r_done | w_hit;
          r_err  <= r_err | w_hit_err;
          if (|w_hit) r_rdata <= w_hit_rdata;
          if (r_timer != '0) r_timer <= r_timer - TimerBits'(1);
          if (w_timeout) begin
            r_err   <= 1'b1;
            r_rdata <= '0;
            r_tmo   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < Outputs; i++) begin
      o_out[i]       = r_out_int;
      o_out[i].read  = w_access & r_out_int.read  & r_sel[i] & ~r_done[i];
      o_out[i].write = w_access & r_out_int.write & r_sel[i] & ~r_done[i];
    end
  end

  always_comb begin
    o_in_fb = '0;
    if (r_state == StRespond) begin
      o_in_fb.ready = 1'b1;
      o_in_fb.error = r_err;
      o_in_fb.rdata = r_rdata;
    end
  end

  assign o_status_miss    = (r_state == StRespond) & r_miss;
  assign o_status_timeout = (r_state == StRespond) & r_tmo;

endmodule

// File: tb/tb_oclib_csr_tree_router.sv
// Directed bench for oclib_csr_tree_router: a 4-output instance with a
// custom key on output 1, 16-cycle timeout and broadcast, plus a 1-output one.
module tb_oclib_csr_tree_router;
  import oclib_pkg::*;

  localparam int N = 4;
  localparam logic [CsrRouterMaxOutputs-1:0][CsrBlockIdBits-1:0] Keys  = {{30{8'hFF}}, 8'h10, 8'hFF};
  localparam logic [CsrRouterMaxOutputs-1:0][CsrBlockIdBits-1:0] Masks = {{30{8'h00}}, 8'h0F, 8'h00};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  csr_32_tree_s    in_req;
  csr_32_tree_fb_s in_fb;
  csr_32_s         out_req [N];
  csr_32_fb_s      out_fb  [N];
  logic            miss, tmo;

  csr_32_tree_s    in1;
  csr_32_tree_fb_s fb1;
  csr_32_s         out1   [1];
  csr_32_fb_s      outfb1 [1];
  logic            miss1, tmo1;

  oclib_csr_tree_router #(
    .Outputs           (N),
    .OutputBlockIdKey  (Keys),
    .OutputBlockIdMask (Masks),
    .TimeoutCycles     (16),
    .EnableBroadcast   (1'b1),
    .BroadcastBlockId  (8'hFF)
  ) dut (
    .i_clock          (clk),
    .i_reset          (rst),
    .i_in             (in_req),
    .o_in_fb          (in_fb),
    .o_out            (out_req),
    .i_out_fb         (out_fb),
    .o_status_miss    (miss),
    .o_status_timeout (tmo)
  );

  oclib_csr_tree_router #(
    .Outputs (1)
  ) dut1 (
    .i_clock          (clk),
    .i_reset          (rst),
    .i_in             (in1),
    .o_in_fb          (fb1),
    .o_out            (out1),
    .i_out_fb         (outfb1),
    .o_status_miss    (miss1),
    .o_status_timeout (tmo1)
  );

  logic [N-1:0] rd_v, wr_v;
  always_comb begin
    for (int i = 0; i < N; i++) begin
      rd_v[i] = out_req[i].read;
      wr_v[i] = out_req[i].write;
    end
  end

  int n_checks = 0;
  int n_errors = 0;
  int n_fb_pulses = 0;
  always @(negedge clk) if (in_fb.ready) n_fb_pulses++;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  int           rdy_cyc [N];
  logic [N-1:0] err_mask;
  logic [31:0]  fb_rdata [N] = '{32'h1111, 32'h2222, 32'hCAFE, 32'h4444};

  int           resp_cyc, miss_cyc, tmo_cyc, pulses, first_act;
  int           last_act [N];
  logic [31:0]  resp_rdata, act_wdata;
  logic         resp_err;
  logic [N-1:0] rd_seen, wr_seen;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_fb(input int k);
    for (int i = 0; i < N; i++) begin
      out_fb[i].ready = (k == rdy_cyc[i]);
      out_fb[i].error = err_mask[i];
      out_fb[i].rdata = fb_rdata[i];
    end
  endtask

  // Request raised at cycle 0 and held through max_cyc; outputs ready per rdy_cyc.
  task automatic run_txn(input logic [7:0] blk, input logic rd, input logic wr,
                         input logic [31:0] wdata, input int max_cyc);
    resp_cyc = -1; miss_cyc = -1; tmo_cyc = -1; pulses = 0; first_act = -1;
    resp_rdata = '0; resp_err = 1'b0; act_wdata = '0; rd_seen = '0; wr_seen = '0;
    for (int i = 0; i < N; i++) last_act[i] = -1;
    in_req         = '0;
    in_req.toblock = blk;
    in_req.read    = rd;
    in_req.write   = wr;
    in_req.address = 32'h100 | {24'h0, blk};
    in_req.wdata   = wdata;
    drive_fb(0);
    for (int k = 1; k <= max_cyc; k++) begin
      cyc();
      for (int i = 0; i < N; i++) begin
        if (rd_v[i] | wr_v[i]) begin
          if (first_act < 0) first_act = k;
          last_act[i] = k;
          act_wdata   = out_req[i].wdata;
        end
      end
      rd_seen |= rd_v;
      wr_seen |= wr_v;
      if (in_fb.ready) begin
        pulses++;
        resp_cyc   = k;
        resp_rdata = in_fb.rdata;
        resp_err   = in_fb.error;
      end
      if (miss) miss_cyc = k;
      if (tmo)  tmo_cyc  = k;
      drive_fb(k);
    end
    in_req = '0;
    for (int i = 0; i < N; i++) rdy_cyc[i] = -1;
    drive_fb(0);
    cyc();
    cyc();
  endtask

  initial begin
    int n0;
    in_req = '0;
    in1    = '0;
    outfb1[0] = '0;
    err_mask = '0;
    for (int i = 0; i < N; i++) rdy_cyc[i] = -1;
    drive_fb(0);
    repeat (3) cyc();

    check("rst_rd", rd_v, 0);
    check("rst_wr", wr_v, 0);
    check("rst_infb", in_fb, 0);
    check("rst_addr", out_req[0].address, 0);
    check("rst_status", {miss, tmo}, 0);
    rst = 1'b0;
    cyc();

    // Read toblock 2; unselected outputs ready early with errors and must be ignored.
    rdy_cyc = '{2, 2, 4, 2}; err_mask = 4'b1011;
    run_txn(8'h02, 1'b1, 1'b0, 32'h0, 16);
    check("t1_rd_seen", rd_seen, 4'b0100);
    check("t1_wr_seen", wr_seen, 0);
    check("t1_first", first_act, 2);
    check("t1_last", last_act[2], 4);
    check("t1_resp_cyc", resp_cyc, 6);
    check("t1_rdata", resp_rdata, 32'hCAFE);
    check("t1_err", resp_err, 0);
    check("t1_pulses_held", pulses, 1);
    check("t1_miss", miss_cyc, -1);

    rdy_cyc = '{-1, 3, -1, -1}; err_mask = '0;
    run_txn(8'h1A, 1'b0, 1'b1, 32'hDEAD_0001, 8);
    check("t2_wr_seen", wr_seen, 4'b0010);
    check("t2_rd_seen", rd_seen, 0);
    check("t2_wdata", act_wdata, 32'hDEAD_0001);
    check("t2_resp_cyc", resp_cyc, 5);
    check("t2_err", resp_err, 0);

    run_txn(8'h2A, 1'b0, 1'b1, 32'h5, 6);
    check("t2m_activity", rd_seen | wr_seen, 0);
    check("t2m_resp_cyc", resp_cyc, 2);
    check("t2m_err", resp_err, 1);
    check("t2m_rdata", resp_rdata, 0);
    check("t2m_miss_cyc", miss_cyc, 2);

    // Output 0 never readies in time; late ready lands in StWait.
    rdy_cyc = '{20, -1, -1, -1};
    run_txn(8'h00, 1'b1, 1'b0, 32'h0, 24);
    check("t3_rd_seen", rd_seen, 4'b0001);
    check("t3_first", first_act, 2);
    check("t3_last", last_act[0], 17);
    check("t3_resp_cyc", resp_cyc, 18);
    check("t3_err", resp_err, 1);
    check("t3_rdata", resp_rdata, 0);
    check("t3_tmo_cyc", tmo_cyc, 18);
    check("t3_pulses", pulses, 1);

    rdy_cyc = '{17, -1, -1, -1};
    run_txn(8'h00, 1'b1, 1'b0, 32'h0, 22);
    check("t3b_resp_cyc", resp_cyc, 19);
    check("t3b_err", resp_err, 0);
    check("t3b_rdata", resp_rdata, 32'h1111);
    check("t3b_tmo", tmo_cyc, -1);

    rdy_cyc = '{2, 5, 9, 4}; err_mask = 4'b1000;
    run_txn(8'hFF, 1'b0, 1'b1, 32'hB0B0, 14);
    check("t4_wr_seen", wr_seen, 4'b1111);
    check("t4_last0", last_act[0], 2);
    check("t4_last1", last_act[1], 5);
    check("t4_last2", last_act[2], 9);
    check("t4_last3", last_act[3], 4);
    check("t4_resp_cyc", resp_cyc, 11);
    check("t4_err", resp_err, 1);
    check("t4_pulses", pulses, 1);
    err_mask = '0;

    run_txn(8'hFF, 1'b1, 1'b0, 32'h0, 6);
    check("t4r_rd_seen", rd_seen, 0);
    check("t4r_resp_cyc", resp_cyc, 2);
    check("t4r_err", resp_err, 1);
    check("t4r_miss_cyc", miss_cyc, 2);

    // Reset while StAccess is driving output 3.
    n0 = n_fb_pulses;
    in_req = '0; in_req.toblock = 8'h03; in_req.read = 1'b1;
    repeat (3) cyc();
    check("t5_active", rd_v, 4'b1000);
    rst = 1'b1;
    cyc();
    check("t5_drop", rd_v | wr_v, 0);
    in_req = '0;
    cyc();
    rst = 1'b0;
    repeat (2) cyc();
    check("t5_no_fb", n_fb_pulses - n0, 0);

    rdy_cyc = '{-1, -1, -1, 3};
    run_txn(8'h03, 1'b1, 1'b1, 32'h77, 8);
    check("tb_wr_seen", wr_seen, 4'b1000);
    check("tb_rd_seen", rd_seen, 0);
    check("tb_resp_cyc", resp_cyc, 5);
    check("tb_err", resp_err, 0);

    // Single-output instance: only toblock 0 decodes.
    in1 = '0; in1.toblock = 8'h01; in1.read = 1'b1;
    repeat (2) cyc();
    check("o1_miss_fb", {fb1.ready, fb1.error, miss1}, 3'b111);
    in1 = '0;
    repeat (2) cyc();
    in1.toblock = 8'h00; in1.read = 1'b1;
    repeat (2) cyc();
    check("o1_rd", out1[0].read, 1);
    outfb1[0].ready = 1'b1; outfb1[0].rdata = 32'h55;
    cyc();
    outfb1[0] = '0;
    cyc();
    check("o1_fb", {fb1.ready, fb1.error, fb1.rdata}, {2'b10, 32'h55});
    in1 = '0;
    repeat (2) cyc();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1);
  end

endmodule
